// File: rtl/sram_nport_bank.sv
// Multi-port SRAM bank with one-hot wordlines, two-stage registered access
// (capture, then execute), write-collision priority and a self-clearing sweep.
module sram_nport_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int PORTS = 2
) (
  input  logic                     srclkpos,
  input  logic                     rst_n,
  input  logic [PORTS*DEPTH-1:0]   word,
  input  logic                     ReadEn,
  input  logic                     WriteEn,
  input  logic [PORTS*WIDTH-1:0]   din,
  input  logic                     clear,
  output logic [PORTS*WIDTH-1:0]   dout,
  output logic                     dout_valid,
  output logic [PORTS-1:0]         addr_err,
  output logic                     busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_CLEAR, S_IDLE} state_e;

  state_e                   state_q, state_d;
  logic [AW-1:0]            cnt_q, cnt_d;

  logic                     rd_en_q, rd_en_d;
  logic                     wr_en_q, wr_en_d;
  logic [PORTS-1:0][AW-1:0] addr_q, addr_d;
  logic [PORTS-1:0]         oh_q, oh_d;
  logic [PORTS*WIDTH-1:0]   din_q, din_d;

  logic [PORTS*WIDTH-1:0]   dout_q, dout_d;
  logic                     dout_valid_q, dout_valid_d;
  logic [PORTS-1:0]         addr_err_q, addr_err_d;

  logic [PORTS-1:0][AW-1:0] dec_addr;
  logic [PORTS-1:0]         dec_oh;
  logic                     accept;

  logic [WIDTH-1:0]         mem [DEPTH];

  // Highest set bit wins; an all-zero slice decodes to row 0.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      // NOTE: every always_comb output gets a default before any condition,
      // otherwise an unassigned path infers a latch.
      dec_addr[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (word[p*DEPTH+i]) dec_addr[p] = AW'(i);
      end
      dec_oh[p] = $onehot(word[p*DEPTH +: DEPTH]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH-1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (clear) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Stage 1: requests are dropped while sweeping and on the edge clear is taken.
  always_comb begin
    accept  = (state_q == S_IDLE) && !clear && (ReadEn || WriteEn);
    rd_en_d = accept && ReadEn;
    wr_en_d = accept && WriteEn;
    addr_d  = accept ? dec_addr : addr_q;
    oh_d    = accept ? dec_oh   : oh_q;
    din_d   = accept ? din      : din_q;
  end

  // Stage 2: reads see the array before this edge's writes land.
  always_comb begin
    dout_d = dout_q;
    if (rd_en_q) begin
      for (int p = 0; p < PORTS; p++) begin
        dout_d[p*WIDTH +: WIDTH] = (addr_q[p] == '0) ? '0 : mem[addr_q[p]];
      end
    end
    dout_valid_d = rd_en_q;
    for (int p = 0; p < PORTS; p++) begin
      addr_err_d[p] = (rd_en_q || wr_en_q) && !oh_q[p];
    end
  end

  always_ff @(posedge srclkpos or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_CLEAR;
      cnt_q        <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      oh_q         <= '0;
      din_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      addr_err_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      oh_q         <= oh_d;
      din_q        <= din_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // NOTE: the array has no reset so it maps onto plain storage; the CLEAR
  // sweep zeroes it instead. Later ports are assigned last, so they win.
  always_ff @(posedge srclkpos) begin
    if (state_q == S_CLEAR) mem[cnt_q] <= '0;
    if (wr_en_q) begin
      for (int p = 0; p < PORTS; p++) begin
        if (oh_q[p] && (addr_q[p] != '0)) mem[addr_q[p]] <= din_q[p*WIDTH +: WIDTH];
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign addr_err   = addr_err_q;
  assign busy       = (state_q == S_CLEAR);

endmodule

// File: tb/tb_sram_nport_bank.sv
// Self-checking bench for sram_nport_bank: directed vector table, hand-written
// clear/reset sequences, and randomized traffic against an array model.
module tb_sram_nport_bank;

  localparam int WIDTH = 16;
  localparam int DEPTH = 32;
  localparam int PORTS = 2;
  localparam int NRAND = 300;

  logic                   srclkpos = 1'b0;
  logic                   rst_n    = 1'b0;
  logic [PORTS*DEPTH-1:0] word     = '0;
  logic                   ReadEn   = 1'b0;
  logic                   WriteEn  = 1'b0;
  logic [PORTS*WIDTH-1:0] din      = '0;
  logic                   clear    = 1'b0;
  logic [PORTS*WIDTH-1:0] dout;
  logic                   dout_valid;
  logic [PORTS-1:0]       addr_err;
  logic                   busy;

  sram_nport_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS)) dut (
    .srclkpos  (srclkpos),
    .rst_n     (rst_n),
    .word      (word),
    .ReadEn    (ReadEn),
    .WriteEn   (WriteEn),
    .din       (din),
    .clear     (clear),
    .dout      (dout),
    .dout_valid(dout_valid),
    .addr_err  (addr_err),
    .busy      (busy)
  );

  always #5 srclkpos = ~srclkpos;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge srclkpos);
    #1;
  endtask

  task automatic set_op(input logic re, input logic we, input logic [63:0] w, input logic [31:0] d);
    ReadEn  = re;
    WriteEn = we;
    word    = w;
    din     = d;
  endtask

  task automatic idle();
    set_op(1'b0, 1'b0, '0, '0);
  endtask

  // Counts edges until busy drops, bounded so a stuck sweep still ends the run.
  task automatic count_sweep(input string name, input bit chk_quiet);
    int n;
    n = 0;
    while (busy && n < 100) begin
      if (chk_quiet) check({name, " no dout_valid while busy"}, 64'(dout_valid), 64'd0);
      tick();
      n++;
    end
    check({name, " busy edges"}, 64'(n), 64'(DEPTH));
  endtask

  typedef struct {
    logic        re;
    logic        we;
    logic [63:0] w;
    logic [31:0] d;
    logic [31:0] exp_dout;
    logic        chk_dout;
    logic        exp_valid;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs [12];

  logic [WIDTH-1:0] model_mem [DEPTH];

  function automatic int hi_idx(input logic [DEPTH-1:0] w);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w[i]) return i;
    end
    return 0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] run_dout, prev_dout;
    logic        prev_valid;
    logic [1:0]  prev_err;
    logic        re, we;
    logic [63:0] w;
    logic [31:0] d;

    vecs[0]  = '{1'b0, 1'b1, {32'h0000_0080, 32'h0000_0008}, {16'h1234, 16'hA5A5}, 32'h0, 1'b0, 1'b0, 2'b00};
    vecs[1]  = '{1'b1, 1'b0, {32'h0000_0080, 32'h0000_0008}, 32'h0, {16'h1234, 16'hA5A5}, 1'b1, 1'b1, 2'b00};
    vecs[2]  = '{1'b0, 1'b1, {32'h0000_0020, 32'h0000_0020}, {16'h2222, 16'h1111}, 32'h0, 1'b0, 1'b0, 2'b00};
    vecs[3]  = '{1'b1, 1'b0, {32'h0000_0020, 32'h0000_0020}, 32'h0, {16'h2222, 16'h2222}, 1'b1, 1'b1, 2'b00};
    vecs[4]  = '{1'b0, 1'b1, {32'h0000_0001, 32'h0000_0001}, {16'hFFFF, 16'hFFFF}, 32'h0, 1'b0, 1'b0, 2'b00};
    vecs[5]  = '{1'b1, 1'b0, {32'h0000_0001, 32'h0000_0001}, 32'h0, 32'h0, 1'b1, 1'b1, 2'b00};
    vecs[6]  = '{1'b0, 1'b1, {32'h0000_0200, 32'h0000_0200}, {16'h00AA, 16'h00AA}, 32'h0, 1'b0, 1'b0, 2'b00};
    vecs[7]  = '{1'b1, 1'b1, {32'h0000_0200, 32'h0000_0200}, {16'h0055, 16'h0055}, {16'h00AA, 16'h00AA}, 1'b1, 1'b1, 2'b00};
    vecs[8]  = '{1'b1, 1'b0, {32'h0000_0200, 32'h0000_0200}, 32'h0, {16'h0055, 16'h0055}, 1'b1, 1'b1, 2'b00};
    vecs[9]  = '{1'b0, 1'b1, {32'h0000_0400, 32'h0000_0006}, {16'h0BAD, 16'hBEEF}, 32'h0, 1'b0, 1'b0, 2'b01};
    vecs[10] = '{1'b1, 1'b0, {32'h0000_0400, 32'h0000_0004}, 32'h0, {16'h0BAD, 16'h0000}, 1'b1, 1'b1, 2'b00};
    vecs[11] = '{1'b1, 1'b0, {32'h0000_0000, 32'h0000_0006}, 32'h0, 32'h0, 1'b1, 1'b1, 2'b11};

    // Reset state and initial sweep.
    repeat (3) @(posedge srclkpos);
    #1;
    check("reset busy", 64'(busy), 64'd1);
    check("reset dout", 64'(dout), 64'd0);
    check("reset dout_valid", 64'(dout_valid), 64'd0);
    check("reset addr_err", 64'(addr_err), 64'd0);
    @(negedge srclkpos);
    rst_n = 1'b1;
    count_sweep("initial sweep", 1'b0);

    for (int r = 0; r < DEPTH; r++) begin
      set_op(1'b1, 1'b0, {32'd1 << r, 32'd1 << r}, '0);
      tick();
      idle();
      tick();
      check($sformatf("sweep read row %0d dout", r), 64'(dout), 64'd0);
      check($sformatf("sweep read row %0d valid", r), 64'(dout_valid), 64'd1);
    end

    for (int v = 0; v < 12; v++) begin
      set_op(vecs[v].re, vecs[v].we, vecs[v].w, vecs[v].d);
      tick();
      idle();
      tick();
      if (vecs[v].chk_dout) check($sformatf("vec%0d dout", v), 64'(dout), 64'(vecs[v].exp_dout));
      check($sformatf("vec%0d dout_valid", v), 64'(dout_valid), 64'(vecs[v].exp_valid));
      check($sformatf("vec%0d addr_err", v), 64'(addr_err), 64'(vecs[v].exp_err));
    end

    // Back-to-back write then read of the same rows.
    set_op(1'b0, 1'b1, {32'h0000_2000, 32'h0000_0800}, {16'h2468, 16'h1357});
    tick();
    set_op(1'b1, 1'b0, {32'h0000_2000, 32'h0000_0800}, '0);
    tick();
    check("b2b write valid", 64'(dout_valid), 64'd0);
    idle();
    tick();
    check("b2b read dout", 64'(dout), 64'({16'h2468, 16'h1357}));
    check("b2b read valid", 64'(dout_valid), 64'd1);

    // Clear sweep with requests held during busy.
    set_op(1'b0, 1'b1, {32'h0000_1000, 32'h0000_0010}, {16'hC0DE, 16'h4444});
    tick();
    set_op(1'b1, 1'b0, {32'h0000_1000, 32'h0000_0010}, '0);
    tick();
    idle();
    tick();
    check("pre-clear dout", 64'(dout), 64'({16'hC0DE, 16'h4444}));
    set_op(1'b1, 1'b0, {32'h0000_1000, 32'h0000_0010}, '0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear busy", 64'(busy), 64'd1);
    count_sweep("clear sweep", 1'b1);
    check("clear end no valid", 64'(dout_valid), 64'd0);
    check("dout held through sweep", 64'(dout), 64'({16'hC0DE, 16'h4444}));
    tick();
    idle();
    tick();
    check("post-clear read valid", 64'(dout_valid), 64'd1);
    check("post-clear read dout", 64'(dout), 64'd0);

    // Reset in the middle of a sweep.
    set_op(1'b0, 1'b1, {32'h0000_1000, 32'h0000_0010}, {16'hC0DE, 16'h4444});
    tick();
    set_op(1'b1, 1'b0, {32'h0000_1000, 32'h0000_0010}, '0);
    tick();
    idle();
    tick();
    check("pre-reset dout", 64'(dout), 64'({16'hC0DE, 16'h4444}));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-sweep reset busy", 64'(busy), 64'd1);
    check("mid-sweep reset dout", 64'(dout), 64'd0);
    check("mid-sweep reset valid", 64'(dout_valid), 64'd0);
    @(negedge srclkpos);
    rst_n = 1'b1;
    count_sweep("restart sweep", 1'b0);
    set_op(1'b1, 1'b0, {32'h0000_1000, 32'h0000_0010}, '0);
    tick();
    idle();
    tick();
    check("post-reset read dout", 64'(dout), 64'd0);
    check("post-reset read valid", 64'(dout_valid), 64'd1);

    // Random traffic, one op per cycle, against the array model.
    for (int r = 0; r < DEPTH; r++) model_mem[r] = '0;
    run_dout   = '0;
    prev_dout  = '0;
    prev_valid = 1'b0;
    prev_err   = '0;
    for (int i = 0; i <= NRAND; i++) begin
      logic [1:0]  cur_err;
      logic [31:0] sl;
      int          idx;
      bit          oh;
      cur_err = '0;
      if (i < NRAND) begin
        re = 1'($urandom_range(0, 1));
        we = 1'($urandom_range(0, 1));
        d  = $urandom;
        for (int p = 0; p < PORTS; p++) begin
          case ($urandom_range(0, 9))
            0:       sl = '0;
            1:       sl = $urandom;
            default: sl = 32'd1 << $urandom_range(0, 7);
          endcase
          w[p*DEPTH +: DEPTH] = sl;
        end
        for (int p = 0; p < PORTS; p++) begin
          sl  = w[p*DEPTH +: DEPTH];
          idx = hi_idx(sl);
          oh  = ($countones(sl) == 1);
          cur_err[p] = (re || we) && !oh;
          if (re) run_dout[p*WIDTH +: WIDTH] = (idx == 0) ? '0 : model_mem[idx];
        end
        for (int p = 0; p < PORTS; p++) begin
          sl  = w[p*DEPTH +: DEPTH];
          idx = hi_idx(sl);
          if (we && $countones(sl) == 1 && idx != 0) model_mem[idx] = d[p*WIDTH +: WIDTH];
        end
        set_op(re, we, w, d);
      end else begin
        re = 1'b0;
        idle();
      end
      tick();
      if (i > 0) begin
        check($sformatf("rand%0d dout", i - 1), 64'(dout), 64'(prev_dout));
        check($sformatf("rand%0d dout_valid", i - 1), 64'(dout_valid), 64'(prev_valid));
        check($sformatf("rand%0d addr_err", i - 1), 64'(addr_err), 64'(prev_err));
      end
      prev_dout  = run_dout;
      prev_valid = re;
      prev_err   = cur_err;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
